// File: rtl/leaf_pkt_pkg.sv
// Leaf packet definitions shared by the BFT-side leaf driver:
// packet width and field positions, driver state encoding, packet builder.
package leaf_pkt_pkg;

    localparam int unsigned PKT_W     = 49;
    localparam int unsigned DEST_W    = 5;
    localparam int unsigned PORT_W    = 4;
    localparam int unsigned SEQ_W     = 7;
    localparam int unsigned DATA_W    = 32;

    localparam int unsigned VALID_BIT = 48;
    localparam int unsigned DEST_MSB  = 47;
    localparam int unsigned DEST_LSB  = 43;
    localparam int unsigned PORT_MSB  = 42;
    localparam int unsigned PORT_LSB  = 39;
    localparam int unsigned SEQ_MSB   = 38;
    localparam int unsigned SEQ_LSB   = 32;
    localparam int unsigned DATA_MSB  = 31;
    localparam int unsigned DATA_LSB  = 0;

    typedef logic [PKT_W-1:0] pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } drv_state_e;

    // Build a leaf packet: valid | dest | port | seq | data
    function automatic pkt_t mk_pkt(
        input logic [DEST_W-1:0] dest,
        input logic [PORT_W-1:0] port,
        input logic [SEQ_W-1:0]  seq,
        input logic [DATA_W-1:0] data
    );
        return {1'b1, dest, port, seq, data};
    endfunction

endpackage

// File: rtl/leaf_retry_timer.sv
// Echo timeout timer and retry counter for the leaf driver.
// timeout: timer has reached TIMEOUT-1; exhausted: no retries left.
module leaf_retry_timer #(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TMR_W     = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tmr_clr,
    input  logic tmr_inc,
    input  logic rty_clr,
    input  logic rty_inc,
    output logic timeout,
    output logic exhausted
);

    localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [RTY_W-1:0] rty_q, rty_d;

    // Next timer / retry count
    always_comb begin
        tmr_d = tmr_q;
        rty_d = rty_q;
        if (tmr_clr) begin
            tmr_d = '0;
        end else if (tmr_inc) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
        if (rty_clr) begin
            rty_d = '0;
        end else if (rty_inc) begin
            rty_d = rty_q + RTY_W'(1);
        end
    end

    // Counter registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmr_q <= '0;
            rty_q <= '0;
        end else begin
            tmr_q <= tmr_d;
            rty_q <= rty_d;
        end
    end

    assign timeout   = (tmr_q == TMR_W'(TIMEOUT - 1));
    assign exhausted = (rty_q >= RTY_W'(MAX_RETRY));

endmodule

// File: rtl/leaf_bft_driver.sv
// BFT-side driver for one leaf page interface: formats stream beats into
// 49-bit leaf packets, strobes them into the page, checks the echo and
// retries on timeout. Optional counters enabled by LEAF_DRV_STATS_EN.
module leaf_bft_driver
    import leaf_pkt_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TMR_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [4:0]        s_dest,
    input  logic [3:0]        s_port,
    input  logic [31:0]       s_data,
    output logic [PKT_W-1:0]  din_leaf_bft2interface,
    output logic              resend,
    output logic              ap_start,
    input  logic [PKT_W-1:0]  dout_leaf_interface2bft,
    output logic              done,
    output logic              busy,
    output logic              err
`ifdef LEAF_DRV_STATS_EN
    ,
    output logic [15:0]       stat_sent,
    output logic [15:0]       stat_retry
`endif
);

    drv_state_e       state_q, state_d;
    pkt_t             din_q, din_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             done_q, done_d;
    logic             ap_start_q, ap_start_d;

    logic tmr_clr, tmr_inc, rty_clr, rty_inc;
    logic timeout, exhausted;
    logic echo_match;

    assign echo_match = (dout_leaf_interface2bft == din_q);

    leaf_retry_timer #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY),
        .TMR_W     (TMR_W)
    ) u_retry_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .tmr_clr   (tmr_clr),
        .tmr_inc   (tmr_inc),
        .rty_clr   (rty_clr),
        .rty_inc   (rty_inc),
        .timeout   (timeout),
        .exhausted (exhausted)
    );

    // Next-state, packet latch and timer control; a match beats a timeout
    always_comb begin
        state_d    = state_q;
        din_d      = din_q;
        seq_d      = seq_q;
        done_d     = 1'b0;
        ap_start_d = ap_start_q | start;
        tmr_clr    = 1'b0;
        tmr_inc    = 1'b0;
        rty_clr    = 1'b0;
        rty_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    din_d   = mk_pkt(s_dest, s_port, seq_q, s_data);
                    state_d = SEND;
                end
            end
            SEND: begin
                tmr_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (echo_match) begin
                    done_d  = 1'b1;
                    seq_d   = seq_q + SEQ_W'(1);
                    rty_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_inc = 1'b1;
                    if (timeout) begin
                        if (!exhausted) begin
                            rty_inc = 1'b1;
                            state_d = SEND;
                        end else begin
                            state_d = ERR;
                        end
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and packet registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            din_q      <= '0;
            seq_q      <= '0;
            done_q     <= 1'b0;
            ap_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            din_q      <= din_d;
            seq_q      <= seq_d;
            done_q     <= done_d;
            ap_start_q <= ap_start_d;
        end
    end

    assign din_leaf_bft2interface = din_q;
    assign resend                 = (state_q == SEND);
    assign s_ready                = (state_q == IDLE);
    assign busy                   = (state_q != IDLE);
    assign err                    = (state_q == ERR);
    assign done                   = done_q;
    assign ap_start               = ap_start_q;

`ifdef LEAF_DRV_STATS_EN
    logic [15:0] stat_sent_q, stat_sent_d;
    logic [15:0] stat_retry_q, stat_retry_d;

    // Saturating counts of completed packets and retry sends
    always_comb begin
        stat_sent_d  = stat_sent_q;
        stat_retry_d = stat_retry_q;
        if (done_q && (stat_sent_q != 16'hFFFF)) begin
            stat_sent_d = stat_sent_q + 16'd1;
        end
        if (rty_inc && (stat_retry_q != 16'hFFFF)) begin
            stat_retry_d = stat_retry_q + 16'd1;
        end
    end

    // Statistics registers, cleared on reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_sent_q  <= '0;
            stat_retry_q <= '0;
        end else begin
            stat_sent_q  <= stat_sent_d;
            stat_retry_q <= stat_retry_d;
        end
    end

    assign stat_sent  = stat_sent_q;
    assign stat_retry = stat_retry_q;
`endif

endmodule

// File: tb/tb_leaf_bft_driver.sv
// Self-checking bench for leaf_bft_driver with a behavioural page model
// (loopback / silent / drop-first-capture) and a done-driven scoreboard.
module tb_leaf_bft_driver;

    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned TMR_W     = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_dest;
    logic [3:0]  s_port;
    logic [31:0] s_data;
    logic [48:0] din;
    logic        resend;
    logic        ap_start;
    logic [48:0] dout;
    logic        done;
    logic        busy;
    logic        err;
`ifdef LEAF_DRV_STATS_EN
    logic [15:0] stat_sent;
    logic [15:0] stat_retry;
`endif

    always #5 clk = ~clk;

    leaf_bft_driver #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY),
        .TMR_W     (TMR_W)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .start                   (start),
        .s_valid                 (s_valid),
        .s_ready                 (s_ready),
        .s_dest                  (s_dest),
        .s_port                  (s_port),
        .s_data                  (s_data),
        .din_leaf_bft2interface  (din),
        .resend                  (resend),
        .ap_start                (ap_start),
        .dout_leaf_interface2bft (dout),
        .done                    (done),
        .busy                    (busy),
        .err                     (err)
`ifdef LEAF_DRV_STATS_EN
        ,
        .stat_sent               (stat_sent),
        .stat_retry              (stat_retry)
`endif
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_done = 0;
    int          cyc = 0;
    int          page_caps = 0;
    int          page_mode = 0;   // 0 loopback, 1 silent, 2 drop one capture
    int          drop_at = -1;
    logic [6:0]  exp_seq = '0;
    logic [48:0] exp_q[$];
    int          resend_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Page model: captures din on resend, holds last capture
    always @(posedge clk) begin
        if (!reset_n) begin
            dout <= '0;
        end else if (resend) begin
            page_caps <= page_caps + 1;
            if (page_mode == 0 || (page_mode == 2 && page_caps != drop_at))
                dout <= din;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: records resend pulses, pops the scoreboard on every done
    initial begin
        forever begin
            @(negedge clk);
            if (resend === 1'b1) resend_q.push_back(cyc);
            if (done === 1'b1) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: din=%h with no packet expected", din);
                end else begin
                    chk("echo_pkt", 64'(din), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_seq = '0;
    endtask

    task automatic send(input logic [4:0] d, input logic [3:0] p, input logic [31:0] x,
                        input bit expect_done);
        int b;
        b = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (s_ready !== 1'b1) chk("s_ready_wait", 64'(s_ready), 64'd1);
        s_valid = 1'b1;
        s_dest  = d;
        s_port  = p;
        s_data  = x;
        if (expect_done) begin
            exp_q.push_back({1'b1, d, p, exp_seq, x});
            exp_seq = exp_seq + 7'd1;
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int b;
        b = 0;
        while (n_done < target && b < budget) begin
            @(negedge clk);
            b++;
        end
        @(negedge clk);
        chk("done_count", 64'(n_done), 64'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rb;
        reset_n = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_dest  = '0;
        s_port  = '0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_din", 64'(din), 64'd0);
        chk("rst_resend", 64'(resend), 64'd0);
        chk("rst_ap_start", 64'(ap_start), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        reset_n = 1'b1;

        // T1: single packet latency and layout
        base = n_done;
        send(5'd3, 4'd1, 32'hDEADBEEF, 1'b1);
        @(negedge clk);   // cycle N+1
        chk("t1_resend_n1", 64'(resend), 64'd1);
        chk("t1_s_ready_n1", 64'(s_ready), 64'd0);
        chk("t1_din", 64'(din), 64'h1_1880_DEAD_BEEF);
        @(negedge clk);   // N+2
        chk("t1_resend_n2", 64'(resend), 64'd0);
        chk("t1_done_n2", 64'(done), 64'd0);
        @(negedge clk);   // N+3
        chk("t1_done_n3", 64'(done), 64'd1);
        chk("t1_s_ready_n3", 64'(s_ready), 64'd1);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_done_cnt", 64'(n_done), 64'(base + 1));

        // T6: start pulse while busy (this packet carries seq 1)
        base = n_done;
        send(5'd17, 4'd9, 32'h0123_4567, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_ap_start", 64'(ap_start), 64'd1);
        wait_done(base + 1, 50);
        repeat (5) @(negedge clk);
        chk("t6_ap_start_held", 64'(ap_start), 64'd1);

        // T3: page drops the first capture only
        do_reset();
        page_mode = 2;
        drop_at   = page_caps;
        rb        = resend_q.size();
        base      = n_done;
        send(5'd4, 4'd2, 32'hA5A5_0F0F, 1'b1);
        wait_done(base + 1, 100);
        chk("t3_resends", 64'(resend_q.size() - rb), 64'd2);
        if (resend_q.size() >= rb + 2)
            chk("t3_spacing", 64'(resend_q[rb+1] - resend_q[rb]), 64'd17);
        chk("t3_err", 64'(err), 64'd0);
`ifdef LEAF_DRV_STATS_EN
        chk("t3_stat_retry", 64'(stat_retry), 64'd1);
        chk("t3_stat_sent", 64'(stat_sent), 64'd1);
`endif

        // T4: 130 back-to-back packets, identical except for seq
        page_mode = 0;
        rb   = resend_q.size();
        base = n_done;
        for (int i = 0; i < 130; i++) send(5'd9, 4'd7, 32'h0000_5A5A, 1'b1);
        wait_done(base + 130, 200);
        chk("t4_resends", 64'(resend_q.size() - rb), 64'd130);
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // T5: reset while waiting on a silent page
        page_mode = 1;
        send(5'd6, 4'd3, 32'h1111_2222, 1'b0);
        repeat (5) @(negedge clk);
        chk("t5_busy_wait", 64'(busy), 64'd1);
        chk("t5_resend_wait", 64'(resend), 64'd0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t5_din", 64'(din), 64'd0);
        chk("t5_resend", 64'(resend), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_err", 64'(err), 64'd0);
        chk("t5_ap_start", 64'(ap_start), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_s_ready", 64'(s_ready), 64'd1);
        reset_n = 1'b1;
        exp_seq = '0;
        page_mode = 0;
        base = n_done;
        send(5'd1, 4'd2, 32'h1234_5678, 1'b1);   // expected with seq 0
        wait_done(base + 1, 50);

        // T2: silent page, retries exhausted
        page_mode = 1;
        rb   = resend_q.size();
        base = n_done;
        send(5'd2, 4'd3, 32'hCAFE_F00D, 1'b0);
        for (int b = 0; b < 150 && err !== 1'b1; b++) @(negedge clk);
        chk("t2_err", 64'(err), 64'd1);
        chk("t2_s_ready", 64'(s_ready), 64'd0);
        chk("t2_resends", 64'(resend_q.size() - rb), 64'd4);
        for (int k = 1; k < 4; k++)
            if (resend_q.size() > rb + k)
                chk("t2_spacing", 64'(resend_q[rb+k] - resend_q[rb+k-1]), 64'd17);
        repeat (30) @(negedge clk);
        chk("t2_err_sticky", 64'(err), 64'd1);
        chk("t2_no_more_resend", 64'(resend_q.size() - rb), 64'd4);
        chk("t2_no_done", 64'(n_done), 64'(base));
        do_reset();
        @(negedge clk);
        chk("t2_err_cleared", 64'(err), 64'd0);
        chk("t2_s_ready_back", 64'(s_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
